// File: rtl/sub_bytes_if.sv
// Handshake/data bundle for the registered AES SubBytes stage.
// Defining SUB_BYTES_INV_EN adds the inv select alongside in_valid.
interface sub_bytes_if;
    logic         in_valid;
    logic [127:0] data_in;
`ifdef SUB_BYTES_INV_EN
    logic         inv;
`endif
    logic         out_valid;
    logic [127:0] data_out;

    modport master (
        output in_valid,
        output data_in,
`ifdef SUB_BYTES_INV_EN
        output inv,
`endif
        input  out_valid,
        input  data_out
    );

    modport slave (
        input  in_valid,
        input  data_in,
`ifdef SUB_BYTES_INV_EN
        input  inv,
`endif
        output out_valid,
        output data_out
    );
endinterface

// File: rtl/sub_bytes.sv
// Registered AES SubBytes: 16 parallel S-box lookups, one clock of latency.
// Optional macro SUB_BYTES_INV_EN adds an inverse S-box selected by bus.inv.
module sub_bytes (
    input logic        clk,
    input logic        rst,
    sub_bytes_if.slave bus
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = '0;
        aa = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse in GF(2^8) and maps 0 to 0 naturally.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] s;
        logic [7:0] r;
        s = x;
        r = 8'h01;
        for (int unsigned i = 0; i < 7; i++) begin
            s = gf_mul(s, s);
            r = gf_mul(r, s);
        end
        return r;
    endfunction

    function automatic logic [7:0] fwd_sbox(input logic [7:0] x);
        logic [7:0] b;
        b = gf_inv(x);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

`ifdef SUB_BYTES_INV_EN
    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        logic [7:0] a;
        a = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
        return gf_inv(a);
    endfunction
`endif

    logic [127:0] sub;

    // Substitution is position-independent, so the byte walk order is irrelevant.
    always_comb begin
        sub = '0;
        for (int unsigned k = 0; k < 16; k++) begin
`ifdef SUB_BYTES_INV_EN
            sub[8*k +: 8] = bus.inv ? inv_sbox(bus.data_in[8*k +: 8])
                                    : fwd_sbox(bus.data_in[8*k +: 8]);
`else
            sub[8*k +: 8] = fwd_sbox(bus.data_in[8*k +: 8]);
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.data_out  <= '0;
        end else begin
            bus.out_valid <= bus.in_valid;
            if (bus.in_valid) bus.data_out <= sub;
        end
    end

endmodule

// File: tb/tb_sub_bytes.sv
// Self-checking bench for sub_bytes: log/antilog reference model plus directed vectors.
module tb_sub_bytes;
    logic clk;
    logic rst;
    logic tb_inv;
    int   total;
    int   bad;

    logic [7:0] sbox  [256];
    logic [7:0] isbox [256];
    logic [7:0] pw    [256];
    int         lg    [256];

    sub_bytes_if bus ();

    sub_bytes dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

`ifdef SUB_BYTES_INV_EN
    assign bus.inv = tb_inv;
`endif

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic logic [127:0] model(input logic [127:0] d, input logic iv);
        logic [127:0] o;
        o = '0;
        for (int k = 0; k < 16; k++)
            o[8*k +: 8] = iv ? isbox[d[8*k +: 8]] : sbox[d[8*k +: 8]];
        return o;
    endfunction

    // Reference: inverse via generator-3 log tables, then the bitwise affine map.
    task automatic build_tables();
        logic [7:0] g;
        logic [7:0] x;
        logic [7:0] y;
        logic [7:0] c;
        c = 8'h63;
        g = 8'h01;
        for (int i = 0; i < 255; i++) begin
            pw[i] = g;
            lg[g] = i;
            g = g ^ ({g[6:0], 1'b0} ^ (g[7] ? 8'h1b : 8'h00));
        end
        for (int v = 0; v < 256; v++) begin
            x = (v == 0) ? 8'h00 : pw[(255 - lg[v]) % 255];
            for (int i = 0; i < 8; i++)
                y[i] = x[i] ^ x[(i+4)%8] ^ x[(i+5)%8] ^ x[(i+6)%8] ^ x[(i+7)%8] ^ c[i];
            sbox[v] = y;
        end
        for (int v = 0; v < 256; v++) isbox[sbox[v]] = v[7:0];
    endtask

    // Expected-state tracker and per-cycle comparison against the DUT.
    logic         ev;
    logic [127:0] ed;
    always @(posedge clk) begin
        logic         r;
        logic         v;
        logic [127:0] d;
        logic         iv;
        r  = rst;
        v  = bus.in_valid;
        d  = bus.data_in;
        iv = 1'b0;
`ifdef SUB_BYTES_INV_EN
        iv = tb_inv;
`endif
        if (r) begin
            ev = 1'b0;
            ed = '0;
        end else begin
            ev = v;
            if (v) ed = model(d, iv);
        end
        #1;
        chk("cyc_out_valid", {127'd0, bus.out_valid}, {127'd0, ev});
        chk("cyc_data_out", bus.data_out, ed);
    end

    task automatic step(input logic r, input logic v, input logic [127:0] d, input logic iv);
        @(negedge clk);
        rst          = r;
        bus.in_valid = v;
        bus.data_in  = d;
        tb_inv       = iv;
        @(posedge clk);
        #2;
    endtask

    initial begin
        logic [127:0] rd;
        total = 0;
        bad   = 0;
        rst          = 1'b1;
        bus.in_valid = 1'b1;
        bus.data_in  = 128'h0123456789abcdef0123456789abcdef;
        tb_inv       = 1'b0;
        build_tables();

        chk("anchor_00", {120'd0, sbox[8'h00]}, 128'h63);
        chk("anchor_01", {120'd0, sbox[8'h01]}, 128'h7c);
        chk("anchor_53", {120'd0, sbox[8'h53]}, 128'hed);
        chk("anchor_ff", {120'd0, sbox[8'hff]}, 128'h16);
        chk("anchor_19", {120'd0, sbox[8'h19]}, 128'hd4);
        chk("anchor_be", {120'd0, sbox[8'hbe]}, 128'hae);
        chk("ianchor_7c", {120'd0, isbox[8'h7c]}, 128'h01);
        chk("ianchor_16", {120'd0, isbox[8'h16]}, 128'hff);

        step(1'b1, 1'b1, 128'hffeeddccbbaa99887766554433221100, 1'b0);
        chk("rst1_valid", {127'd0, bus.out_valid}, 128'd0);
        chk("rst1_data", bus.data_out, 128'd0);
        step(1'b1, 1'b1, 128'h00112233445566778899aabbccddeeff, 1'b0);
        chk("rst2_data", bus.data_out, 128'd0);
        step(1'b0, 1'b0, 'x, 1'b0);
        chk("idle_valid", {127'd0, bus.out_valid}, 128'd0);
        chk("idle_data", bus.data_out, 128'd0);

        step(1'b0, 1'b1, 128'h193de3be_a0f4e22b_9ac68d2a_e9f84808, 1'b0);
        chk("vec1_valid", {127'd0, bus.out_valid}, 128'd1);
        chk("vec1_data", bus.data_out, 128'hd42711ae_e0bf98f1_b8b45de5_1e415230);
        step(1'b0, 1'b0, 'x, 1'b0);
        chk("vec1_hold_valid", {127'd0, bus.out_valid}, 128'd0);
        chk("vec1_hold_data", bus.data_out, 128'hd42711ae_e0bf98f1_b8b45de5_1e415230);

        step(1'b0, 1'b1, 128'ha49c7ff2_689f352b_6b5bea43_026a5049, 1'b0);
        chk("b2b_a", bus.data_out, 128'h49ded289_45db96f1_7f39871a_7702533b);
        step(1'b0, 1'b1, 128'haa8f5f03_61dde3ef_82d24ad2_6832469a, 1'b0);
        chk("b2b_b_valid", {127'd0, bus.out_valid}, 128'd1);
        chk("b2b_b", bus.data_out, 128'hac73cf7b_efc111df_13b5d6b5_45235ab8);

        step(1'b0, 1'b1, '0, 1'b0);
        chk("all_zero", bus.data_out, {16{8'h63}});
        step(1'b0, 1'b1, '1, 1'b0);
        chk("all_ones", bus.data_out, {16{8'h16}});
        step(1'b0, 1'b1, 128'h00010203_04050607_08090a0b_0c0d0e0f, 1'b0);
        chk("ramp", bus.data_out, 128'h637c777b_f26b6fc5_3001672b_fed7ab76);

        step(1'b1, 1'b1, 128'h193de3be_a0f4e22b_9ac68d2a_e9f84808, 1'b0);
        chk("rst_mid_valid", {127'd0, bus.out_valid}, 128'd0);
        chk("rst_mid_data", bus.data_out, 128'd0);
        step(1'b0, 1'b0, 'x, 1'b0);
        chk("rst_no_stale_valid", {127'd0, bus.out_valid}, 128'd0);
        chk("rst_no_stale_data", bus.data_out, 128'd0);

`ifdef SUB_BYTES_INV_EN
        step(1'b0, 1'b1, 128'hd42711ae_e0bf98f1_b8b45de5_1e415230, 1'b1);
        chk("inv_vec", bus.data_out, 128'h193de3be_a0f4e22b_9ac68d2a_e9f84808);
        step(1'b0, 1'b1, {16{8'h63}}, 1'b1);
        chk("inv_zero", bus.data_out, 128'd0);
`endif

        for (int n = 0; n < 400; n++) begin
            logic v;
            logic r;
            logic iv;
            v  = ($urandom_range(0, 3) != 0);
            r  = ($urandom_range(0, 31) == 0);
            iv = 1'b0;
`ifdef SUB_BYTES_INV_EN
            iv = $urandom_range(0, 1) == 1;
`endif
            rd = {$urandom, $urandom, $urandom, $urandom};
            if (!v && $urandom_range(0, 1) == 1) rd = 'x;
            step(r, v, rd, iv);
        end

        step(1'b0, 1'b0, 'x, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
